// File: rtl/mult_taint_pkg.sv
// Shared definitions for the taint-tracked multiplier and its result buffer.
// Buffer entries are packed as {data[2W-1:0], dt, ct}.
package mult_taint_pkg;

    localparam int WIDTH_DEFAULT  = 4;
    localparam int DEPTH_DEFAULT  = 4;

    localparam int ENTRY_CT_BIT   = 0;
    localparam int ENTRY_DT_BIT   = 1;
    localparam int ENTRY_DATA_LSB = 2;

    function automatic int entry_width(input int width);
        return 2 * width + 2;
    endfunction

    function automatic bit depth_is_valid(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/taint_fifo.sv
// Generic DEPTH x EW FIFO with per-slot valid bits so the control-taint bit
// of every occupied entry can be OR-reduced.
module taint_fifo
    import mult_taint_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int EW    = entry_width(WIDTH_DEFAULT),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] wr_entry,
    output logic [EW-1:0] rd_entry,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ct_any
);

    localparam int PW = $clog2(DEPTH);

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ct_any_s;

    // Next-state: pop clears a slot before push sets one, so a full push+pop reuses the head slot.
    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
            vld_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Control taint of any occupied slot.
    always_comb begin
        ct_any_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ct_any_s = ct_any_s | (vld_q[i] & mem_q[i][ENTRY_CT_BIT]);
        end
    end

    assign rd_entry = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == {CW{1'b0}});
    assign ct_any   = ct_any_s;

endmodule

// File: rtl/mult_result_buffer_taint.sv
// Captures each completed multiplier product (on a fresh productDone edge) into a
// FIFO, keeping data taint and control/timing taint separate all the way out.
module mult_result_buffer_taint
    import mult_taint_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*WIDTH-1:0] product,
    input  logic             product_t,
    input  logic             productDone,
    input  logic             productDone_t,
    output logic             out_valid,
    output logic             out_valid_t,
    input  logic             out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic             out_data_t,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             overflow_t,
    output logic             taint_seen
);

    localparam int EW = entry_width(WIDTH);

    if (!depth_is_valid(DEPTH)) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end

    logic          done_q, done_d;
    logic          done_t_q, done_t_d;
    logic          overflow_q, overflow_d;
    logic          overflow_t_q, overflow_t_d;
    logic          taint_seen_q, taint_seen_d;
    logic          cap_s, cap_t_s, pop_s, push_s, drop_s;
    logic          full_s, empty_s, ct_any_s;
    logic [EW-1:0] wr_entry_s, rd_entry_s;

    assign cap_s      = productDone & ~done_q;
    assign cap_t_s    = productDone_t | done_t_q;
    assign pop_s      = ~empty_s & out_ready;
    assign push_s     = cap_s & (~full_s | pop_s);
    assign drop_s     = cap_s & full_s & ~pop_s;
    assign wr_entry_s = {product, product_t, cap_t_s};

    taint_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .wr_entry (wr_entry_s),
        .rd_entry (rd_entry_s),
        .full     (full_s),
        .empty    (empty_s),
        .count    (count),
        .ct_any   (ct_any_s)
    );

    // Edge detector and sticky status next-state.
    always_comb begin
        done_d       = productDone;
        done_t_d     = productDone_t;
        overflow_d   = overflow_q | drop_s;
        overflow_t_d = overflow_t_q | (drop_s & (cap_t_s | ct_any_s));
        taint_seen_d = taint_seen_q | (push_s & (product_t | cap_t_s));
    end

    // done_q resets high so a level already high at reset release is not a capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q       <= 1'b1;
            done_t_q     <= 1'b0;
            overflow_q   <= 1'b0;
            overflow_t_q <= 1'b0;
            taint_seen_q <= 1'b0;
        end else begin
            done_q       <= done_d;
            done_t_q     <= done_t_d;
            overflow_q   <= overflow_d;
            overflow_t_q <= overflow_t_d;
            taint_seen_q <= taint_seen_d;
        end
    end

    // Head presentation; stale slot contents are hidden while empty.
    always_comb begin
        if (empty_s) begin
            out_data   = {(2*WIDTH){1'b0}};
            out_data_t = 1'b0;
        end else begin
            out_data   = rd_entry_s[EW-1:ENTRY_DATA_LSB];
            out_data_t = rd_entry_s[ENTRY_DT_BIT];
        end
    end

    assign out_valid   = ~empty_s;
    assign out_valid_t = ct_any_s;
    assign overflow    = overflow_q;
    assign overflow_t  = overflow_t_q;
    assign taint_seen  = taint_seen_q;

endmodule
